// File: rtl/tdc_phase_detector_if.sv
// rtl/tdc_phase_detector_if.sv - control, sampled clock inputs and phase-error outputs of the PFD
interface tdc_phase_detector_if #(
  parameter int ERROR_WIDTH = 8
);
  logic                          enable_i;
  logic                          ref_i;
  logic                          fb_i;
  logic signed [ERROR_WIDTH-1:0] error_o;
  logic                          valid_o;
  logic                          lock_o;

  modport master (
    output enable_i, ref_i, fb_i,
    input  error_o, valid_o, lock_o
  );

  modport slave (
    input  enable_i, ref_i, fb_i,
    output error_o, valid_o, lock_o
  );
endinterface

// File: rtl/tdc_phase_detector.sv
// rtl/tdc_phase_detector.sv - counter-based phase/frequency detector with lock indicator
module tdc_phase_detector #(
  parameter int ERROR_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_COUNT  = 16
) (
  input logic                   gen_clk_i,
  input logic                   reset_ni,
  tdc_phase_detector_if.slave   bus
);
  localparam int CW = ERROR_WIDTH - 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] MAX = {CW{1'b1}};
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_COUNT);
  localparam logic [ERROR_WIDTH-1:0] TOL = ERROR_WIDTH'(LOCK_TOL);

  typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
  logic ref_dly, fb_dly;
  logic ref_rise, fb_rise;
  logic [CW-1:0] count, count_nxt, count_inc;
  logic emit;
  logic [ERROR_WIDTH-1:0] emit_val, pos_count, pos_max, err_mag;
  logic [LW-1:0] lock_cnt;
  logic in_tol;

  // Synchronizers and edge detectors run regardless of enable so re-enabling sees no false edge
  always_ff @(posedge gen_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_dly  <= 1'b0;
      fb_dly   <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], bus.ref_i};
      fb_sync  <= {fb_sync[SYNC_STAGES-2:0], bus.fb_i};
      ref_dly  <= ref_sync[SYNC_STAGES-1];
      fb_dly   <= fb_sync[SYNC_STAGES-1];
    end
  end

  assign ref_rise  = ref_sync[SYNC_STAGES-1] & ~ref_dly;
  assign fb_rise   = fb_sync[SYNC_STAGES-1] & ~fb_dly;
  assign count_inc = (count == MAX) ? MAX : count + ONE;
  assign pos_count = {1'b0, count};
  assign pos_max   = {1'b0, MAX};

  always_ff @(posedge gen_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      count       <= '0;
      bus.error_o <= '0;
      bus.valid_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      bus.valid_o <= emit;
      if (emit) bus.error_o <= emit_val;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    emit      = 1'b0;
    emit_val  = '0;
    if (!bus.enable_i) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_rise && fb_rise) begin
            emit = 1'b1;
          end else if (ref_rise) begin
            count_nxt = ONE;
            state_nxt = REF_LEAD;
          end else if (fb_rise) begin
            count_nxt = ONE;
            state_nxt = FB_LEAD;
          end
        end
        REF_LEAD: begin
          if (fb_rise) begin
            emit     = 1'b1;
            emit_val = pos_count;
            if (ref_rise) count_nxt = ONE;
            else          state_nxt = IDLE;
          end else if (ref_rise) begin
            // Second reference edge before any feedback: report full-scale and restart
            emit      = 1'b1;
            emit_val  = pos_max;
            count_nxt = ONE;
          end else begin
            count_nxt = count_inc;
          end
        end
        FB_LEAD: begin
          if (ref_rise) begin
            emit     = 1'b1;
            emit_val = -pos_count;
            if (fb_rise) count_nxt = ONE;
            else         state_nxt = IDLE;
          end else if (fb_rise) begin
            emit      = 1'b1;
            emit_val  = -pos_max;
            count_nxt = ONE;
          end else begin
            count_nxt = count_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  // error_o never reaches -2^(W-1), so the two's-complement negation cannot overflow
  assign err_mag = bus.error_o[ERROR_WIDTH-1] ? -bus.error_o : bus.error_o;
  assign in_tol  = (err_mag <= TOL);

  always_ff @(posedge gen_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lock_cnt   <= '0;
      bus.lock_o <= 1'b0;
    end else if (!bus.enable_i) begin
      lock_cnt   <= '0;
      bus.lock_o <= 1'b0;
    end else begin
      if (bus.valid_o) begin
        if (!in_tol)                     lock_cnt <= '0;
        else if (lock_cnt != LOCK_FULL)  lock_cnt <= lock_cnt + 1'b1;
      end
      bus.lock_o <= (lock_cnt == LOCK_FULL);
    end
  end
endmodule
